stream_loader: RTL



---
 rtl/stream_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/stream_loader.sv
// -----------------------------------------------------------------------------
// stream_loader
//   Moves a bounded stream of words from a valid/ready source into a FIFO.
//   Each stream starts with a one-cycle pointer-clear pulse to the FIFO.
//   The FIFO then receives up to the requested number of words, with no
//   data register between the source and the FIFO. The stream ends in a
//   single FINISH cycle that pulses done_o.
//
// Ports
//   clk_i, rst_ni       clock, async active-low reset
//   start_i, len_i      stream request; len_i is sampled with start_i and
//                       clamped to MAX_LEN; len_i == 0 goes straight to
//                       FINISH
//   abort_i             ends the current stream (CLEAR/STREAM only)
//   s_valid_i, s_data_i upstream word
//   s_ready_o           upstream ready (STREAM, FIFO not full, no abort)
//   fifo_full_i         FIFO full flag, the only backpressure source
//   fifo_wr_en_o        FIFO write strobe (= s_valid_i & s_ready_o)
//   fifo_data_o         FIFO write data (= s_data_i)
//   fifo_new_stream_o   one-cycle FIFO pointer clear, issued in CLEAR
//   busy_o              state != IDLE
//   done_o, aborted_o   end-of-stream pulse; aborted_o qualifies done_o
//   words_o             words accepted in the current or last stream
// -----------------------------------------------------------------------------
module stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [$clog2(MAX_LEN):0]   len_i,
  input  logic                       abort_i,
  input  logic                       s_valid_i,
  input  logic [DATA_WIDTH-1:0]      s_data_i,
  output logic                       s_ready_o,
  input  logic                       fifo_full_i,
  output logic                       fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]      fifo_data_o,
  output logic                       fifo_new_stream_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       aborted_o,
  output logic [$clog2(MAX_LEN):0]   words_o
);

  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e          state_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   words_q;
  logic [LW-1:0]   words_inc;
  logic            done_q;
  logic            aborted_q;
  logic            new_stream_q;
  logic            last_write;

  // Datapath is pure wiring: the source talks straight to the FIFO.
  // abort_i kills ready in the same cycle so an aborting cycle never writes.
  // Reset forces the state to IDLE asynchronously. The rst_ni term keeps
  // ready low even while the state register is settling into reset.
  assign s_ready_o    = rst_ni && (state_q == STREAM) && !fifo_full_i && !abort_i;
  assign fifo_wr_en_o = s_valid_i && s_ready_o;
  assign fifo_data_o  = s_data_i;

  assign words_inc  = words_q + LW'(1);
  // The write that reaches the latched length closes the stream. The state
  // leaves STREAM on that edge, so no further word can be accepted.
  assign last_write = fifo_wr_en_o && (words_inc == len_q);

  assign busy_o            = (state_q != IDLE);
  assign done_o            = done_q;
  assign aborted_o         = aborted_q;
  assign fifo_new_stream_o = new_stream_q;
  assign words_o           = words_q;

  // The pulse outputs are registered on the transition into the state that
  // owns them. CLEAR therefore sees new_stream high, and FINISH sees
  // done/aborted high, for exactly one cycle each.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      len_q        <= '0;
      words_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      new_stream_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      new_stream_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            words_q <= '0;
            if (len_i == '0) begin
              // Empty stream: no FIFO clear, just report completion.
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              len_q        <= (len_i > MAX_LEN_W) ? MAX_LEN_W : len_i;
              state_q      <= CLEAR;
              new_stream_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // The clear pulse is already on the wire this cycle. An abort
          // here only redirects the next state.
          if (abort_i) begin
            state_q   <= FINISH;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (abort_i) begin
            state_q   <= FINISH;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (fifo_wr_en_o) begin
            words_q <= words_inc;
            if (last_write) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
